// File: rtl/lap_stopwatch_core.sv
// Stopwatch/timer core: run-state FSM, prescaled up/down time counter with countdown expiry,
// validated presets and a lap-capture buffer. Time layout hour[23:19] min[18:13] sec[12:7] frac[6:0].
module lap_stopwatch_core #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned HOUR_MAX  = 24,
  parameter int unsigned LAP_DEPTH = 4,
  localparam int unsigned IDX_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int unsigned CNT_W    = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run_stop,
  input  logic             i_clear,
  input  logic             i_count_mode,
  input  logic             i_lap,
  input  logic [IDX_W-1:0] i_lap_rd_idx,
  input  logic             i_preset_valid,
  input  logic [23:0]      i_preset_time,
  output logic [23:0]      o_time,
  output logic [23:0]      o_lap_time,
  output logic [CNT_W-1:0] o_lap_count,
  output logic             o_lap_full,
  output logic             o_running,
  output logic             o_expired,
  output logic             o_rollover,
  output logic             o_preset_err
);

  localparam int unsigned     DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned     PS_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(DIV - 1);
  localparam logic [6:0]      FRAC_MOD  = 7'(TICK_HZ);
  localparam logic [6:0]      FRAC_LAST = 7'(TICK_HZ - 1);
  localparam logic [5:0]      SIX_LAST  = 6'd59;
  localparam logic [5:0]      HOUR_MOD  = 6'(HOUR_MAX);
  localparam logic [4:0]      HOUR_LAST = 5'(HOUR_MAX - 1);
  localparam logic [CNT_W-1:0] LAP_FULL = CNT_W'(LAP_DEPTH);
  localparam logic [CNT_W-1:0] LAP_LAST = CNT_W'(LAP_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t          state, state_nxt;
  logic [PS_W-1:0] ps;
  logic [23:0]     lap_mem [LAP_DEPTH];
  logic [23:0]     time_nxt;
  logic            rollover_nxt;
  logic            wrap;

  logic [4:0] t_hour, p_hour, n_hour;
  logic [5:0] t_min, t_sec, p_min, p_sec, n_min, n_sec;
  logic [6:0] t_frac, p_frac, n_frac;

  assign {t_hour, t_min, t_sec, t_frac} = o_time;
  assign {p_hour, p_min, p_sec, p_frac} = i_preset_time;

  logic time_zero, preset_ok, preset_take, preset_rej, tick, lap_write;

  assign time_zero   = (o_time == 24'd0);
  assign preset_ok   = (p_frac < FRAC_MOD) && (p_sec <= SIX_LAST) && (p_min <= SIX_LAST) &&
                       ({1'b0, p_hour} < HOUR_MOD);
  assign preset_take = i_preset_valid && !i_clear && preset_ok && (state != RUN);
  // Clear outranks a preset, so a preset swallowed by clear is not reported as rejected.
  assign preset_rej  = i_preset_valid && !i_clear && !preset_take;
  assign tick        = (state == RUN) && (ps == PS_LAST) && !i_clear;
  assign lap_write   = i_lap && !i_clear && (o_lap_count != LAP_FULL);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a down-count tick at zero expires instead of wrapping
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else if (preset_take) begin
      if (state == EXPIRED) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_run_stop) state_nxt = RUN;
        RUN: begin
          if (tick && i_count_mode && time_zero) state_nxt = EXPIRED;
          else if (!i_run_stop)                  state_nxt = PAUSE;
        end
        PAUSE:   if (i_run_stop) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // Time update: increment/decrement with per-field carry or borrow
  always_comb begin
    n_hour = t_hour;
    n_min  = t_min;
    n_sec  = t_sec;
    n_frac = t_frac;
    wrap   = 1'b0;
    if (!i_count_mode) begin
      if (t_frac == FRAC_LAST) begin
        n_frac = 7'd0;
        if (t_sec == SIX_LAST) begin
          n_sec = 6'd0;
          if (t_min == SIX_LAST) begin
            n_min = 6'd0;
            if (t_hour == HOUR_LAST) begin
              n_hour = 5'd0;
              wrap   = 1'b1;
            end else begin
              n_hour = t_hour + 5'd1;
            end
          end else begin
            n_min = t_min + 6'd1;
          end
        end else begin
          n_sec = t_sec + 6'd1;
        end
      end else begin
        n_frac = t_frac + 7'd1;
      end
    end else begin
      if (t_frac == 7'd0) begin
        n_frac = FRAC_LAST;
        if (t_sec == 6'd0) begin
          n_sec = SIX_LAST;
          if (t_min == 6'd0) begin
            n_min  = SIX_LAST;
            n_hour = (t_hour == 5'd0) ? HOUR_LAST : t_hour - 5'd1;
          end else begin
            n_min = t_min - 6'd1;
          end
        end else begin
          n_sec = t_sec - 6'd1;
        end
      end else begin
        n_frac = t_frac - 7'd1;
      end
    end

    time_nxt     = o_time;
    rollover_nxt = 1'b0;
    if (i_clear) begin
      time_nxt = 24'd0;
    end else if (preset_take) begin
      time_nxt = i_preset_time;
    end else if (tick && !(i_count_mode && time_zero)) begin
      time_nxt     = {n_hour, n_min, n_sec, n_frac};
      rollover_nxt = wrap && !i_count_mode;
    end
  end

  // Time, prescaler and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps           <= '0;
      o_time       <= 24'd0;
      o_rollover   <= 1'b0;
      o_preset_err <= 1'b0;
      o_running    <= 1'b0;
      o_expired    <= 1'b0;
    end else begin
      o_time       <= time_nxt;
      o_rollover   <= rollover_nxt;
      o_preset_err <= preset_rej;
      o_running    <= (state_nxt == RUN);
      o_expired    <= (state_nxt == EXPIRED);
      if (i_clear || state == IDLE || state_nxt == EXPIRED) ps <= '0;
      else if (state == RUN) ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
  end

  // Lap buffer: append pre-update time, drop when full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lap_count <= '0;
      o_lap_full  <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem[i] <= 24'd0;
    end else if (i_clear) begin
      o_lap_count <= '0;
      o_lap_full  <= 1'b0;
    end else if (lap_write) begin
      for (int i = 0; i < int'(LAP_DEPTH); i++)
        if (o_lap_count == CNT_W'(i)) lap_mem[i] <= o_time;
      o_lap_count <= o_lap_count + CNT_W'(1);
      o_lap_full  <= (o_lap_count == LAP_LAST);
    end
  end

  always_comb begin
    o_lap_time = 24'd0;
    for (int i = 0; i < int'(LAP_DEPTH); i++)
      if ((CNT_W'(i_lap_rd_idx) == CNT_W'(i)) && (CNT_W'(i) < o_lap_count))
        o_lap_time = lap_mem[i];
  end

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Self-checking bench for lap_stopwatch_core with CLK_HZ=1000, TICK_HZ=100 (10 clocks per tick).
module tb_lap_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run_stop, i_clear, i_count_mode, i_lap, i_preset_valid;
  logic [1:0]  i_lap_rd_idx;
  logic [23:0] i_preset_time;
  logic [23:0] o_time, o_lap_time;
  logic [2:0]  o_lap_count;
  logic        o_lap_full, o_running, o_expired, o_rollover, o_preset_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  lap_stopwatch_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24), .LAP_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
    .i_count_mode(i_count_mode), .i_lap(i_lap), .i_lap_rd_idx(i_lap_rd_idx),
    .i_preset_valid(i_preset_valid), .i_preset_time(i_preset_time),
    .o_time(o_time), .o_lap_time(o_lap_time), .o_lap_count(o_lap_count),
    .o_lap_full(o_lap_full), .o_running(o_running), .o_expired(o_expired),
    .o_rollover(o_rollover), .o_preset_err(o_preset_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] tm(input int h, input int m, input int s, input int f);
    return {5'(h), 6'(m), 6'(s), 7'(f)};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    i_clear = 1'b1; cyc(); i_clear = 1'b0;
  endtask

  task automatic do_preset(input logic [23:0] v);
    i_preset_valid = 1'b1; i_preset_time = v; cyc(); i_preset_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    reset = 1'b1; cyc(2);
    exp_q.push_back(24'd0);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL reset_time: got %h expected %h", o_time, e); end
    n_tests++; if ({o_lap_count, o_lap_full, o_running, o_expired, o_rollover, o_preset_err} !== 8'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0", {o_lap_count, o_lap_full, o_running, o_expired, o_rollover, o_preset_err}); end
    reset = 1'b0; cyc(2);
    n_tests++; if ({o_time, o_lap_time, o_running} !== 49'd0) begin n_fail++; $display("FAIL post_reset_idle: time %h lap %h run %b expected 0", o_time, o_lap_time, o_running); end
  endtask

  task automatic test_run_pause();
    logic [23:0] e;
    // 249 counting edges, then the pause edge counts once more; 49 + 1 after resume
    exp_q.push_back(tm(0,0,0,24)); exp_q.push_back(tm(0,0,0,25));
    exp_q.push_back(tm(0,0,0,29)); exp_q.push_back(tm(0,0,0,30));
    i_count_mode = 1'b0; i_run_stop = 1'b1; cyc(250);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e || o_running !== 1'b1) begin n_fail++; $display("FAIL run_250: time %h run %b expected %h run 1", o_time, o_running, e); end
    i_run_stop = 1'b0; cyc(100);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e || o_running !== 1'b0) begin n_fail++; $display("FAIL pause_100: time %h run %b expected %h run 0", o_time, o_running, e); end
    i_run_stop = 1'b1; cyc(50);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL resume_50: got %h expected %h", o_time, e); end
    i_run_stop = 1'b0; cyc(20);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL run_pause_final: got %h expected %h", o_time, e); end
    // Prescaler phase kept across a pause: 4 + 1 edges, pause, then 4 + 1 more completes a tick
    do_clear();
    exp_q.push_back(tm(0,0,0,0)); exp_q.push_back(tm(0,0,0,1));
    i_run_stop = 1'b1; cyc(5); i_run_stop = 1'b0; cyc(20); i_run_stop = 1'b1; cyc(5);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL ps_hold_before: got %h expected %h", o_time, e); end
    cyc();
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL ps_hold_tick: got %h expected %h", o_time, e); end
    i_run_stop = 1'b0; cyc();
  endtask

  task automatic test_up_wrap();
    logic [23:0] e;
    int roll_cnt = 0, roll_at = 0, zero_at = 0;
    do_clear();
    exp_q.push_back(tm(23,59,59,99));
    do_preset(tm(23,59,59,99));
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e || o_preset_err !== 1'b0) begin n_fail++; $display("FAIL wrap_preset: time %h err %b expected %h err 0", o_time, o_preset_err, e); end
    i_run_stop = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (o_rollover) begin roll_cnt++; roll_at = k; end
      if (o_time == 24'd0 && zero_at == 0) zero_at = k;
    end
    i_run_stop = 1'b0; cyc();
    n_tests++; if (roll_cnt != 1 || roll_at != 11) begin n_fail++; $display("FAIL wrap_rollover: pulses %0d at %0d expected 1 at 11", roll_cnt, roll_at); end
    n_tests++; if (zero_at != 11) begin n_fail++; $display("FAIL wrap_zero: cycle %0d expected 11", zero_at); end
  endtask

  task automatic test_down_expiry();
    logic [23:0] e;
    int zero_at = 0, exp_at = 0, bad = 0;
    do_clear();
    do_preset(tm(0,0,1,0));
    i_count_mode = 1'b1; i_run_stop = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      cyc();
      if (o_time == 24'd0 && zero_at == 0) zero_at = k;
      if (o_expired && exp_at == 0) exp_at = k;
      if (zero_at != 0 && o_time != 24'd0) bad++;
    end
    n_tests++; if (zero_at != 1001) begin n_fail++; $display("FAIL down_zero: cycle %0d expected 1001", zero_at); end
    n_tests++; if (exp_at != 1011) begin n_fail++; $display("FAIL down_expired: cycle %0d expected 1011", exp_at); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL down_hold_zero: %0d nonzero cycles expected 0", bad); end
    i_run_stop = 1'b0; cyc(3); i_run_stop = 1'b1; cyc(15);
    n_tests++; if ({o_expired, o_running, o_time} !== {2'b10, 24'd0}) begin
      n_fail++; $display("FAIL expired_sticky: exp %b run %b time %h expected 1 0 0", o_expired, o_running, o_time); end
    i_run_stop = 1'b0;
    exp_q.push_back(tm(0,0,0,5));
    do_preset(tm(0,0,0,5));
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e || o_expired !== 1'b0 || o_preset_err !== 1'b0) begin
      n_fail++; $display("FAIL expired_preset: time %h exp %b err %b expected %h 0 0", o_time, o_expired, o_preset_err, e); end
    i_run_stop = 1'b1; cyc();
    n_tests++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL run_after_preset: got %b expected 1", o_running); end
    i_run_stop = 1'b0; cyc(); i_count_mode = 1'b0;
  endtask

  task automatic test_preset_guard();
    logic [23:0] e;
    logic [23:0] bad_tab [4];
    int err_cnt = 0;
    bad_tab[0] = tm(0,0,60,0); bad_tab[1] = tm(0,0,0,100);
    bad_tab[2] = tm(0,60,0,0); bad_tab[3] = tm(24,0,0,0);
    do_clear();
    do_preset(tm(0,0,2,3));
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(tm(0,0,2,3));
      do_preset(bad_tab[j]);
      err_cnt += int'(o_preset_err);
      e = exp_q.pop_front();
      n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL guard_idle_%0d: time %h expected %h", j, o_time, e); end
      cyc();
      n_tests++; if (o_preset_err !== 1'b0) begin n_fail++; $display("FAIL guard_pulse_%0d: err %b expected 0", j, o_preset_err); end
    end
    i_run_stop = 1'b1; cyc(5);
    exp_q.push_back(tm(0,0,2,3));
    do_preset(tm(0,10,0,0));
    err_cnt += int'(o_preset_err);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL guard_run_time: got %h expected %h", o_time, e); end
    i_run_stop = 1'b0; cyc();
    n_tests++; if (err_cnt != 5) begin n_fail++; $display("FAIL guard_err_count: got %0d expected 5", err_cnt); end
  endtask

  task automatic test_laps();
    logic [23:0] e;
    int pushed = 0;
    do_clear();
    i_run_stop = 1'b1; cyc();
    for (int c = 1; c <= 50; c++) begin
      i_lap = (c == 3 || c == 10 || c == 15 || c == 27 || c == 40 || c == 45);
      if (i_lap && pushed < 4) begin exp_q.push_back(tm(0,0,0,(c - 1) / 10)); pushed++; end
      cyc();
      i_lap = 1'b0;
      if (c == 12) begin
        n_tests++; if (o_lap_count !== 3'd2) begin n_fail++; $display("FAIL lap_count_mid: got %0d expected 2", o_lap_count); end
        for (int j = 2; j < 4; j++) begin
          i_lap_rd_idx = 2'(j); #1;
          n_tests++; if (o_lap_time !== 24'd0) begin n_fail++; $display("FAIL lap_beyond_%0d: got %h expected 0", j, o_lap_time); end
        end
      end
    end
    i_run_stop = 1'b0; cyc();
    n_tests++; if (o_lap_count !== 3'd4 || o_lap_full !== 1'b1) begin
      n_fail++; $display("FAIL lap_full: count %0d full %b expected 4 1", o_lap_count, o_lap_full); end
    for (int j = 0; j < 4; j++) begin
      i_lap_rd_idx = 2'(j); #1;
      e = exp_q.pop_front();
      n_tests++; if (o_lap_time !== e) begin n_fail++; $display("FAIL lap_entry_%0d: got %h expected %h", j, o_lap_time, e); end
    end
    i_lap_rd_idx = 2'd0;
  endtask

  task automatic test_clear_reset();
    logic [23:0] e;
    i_clear = 1'b1; i_preset_valid = 1'b1; i_preset_time = tm(0,0,5,0);
    cyc();
    i_clear = 1'b0; i_preset_valid = 1'b0;
    n_tests++; if ({o_time, o_lap_count, o_lap_full, o_preset_err, o_running} !== 31'd0) begin
      n_fail++; $display("FAIL clear_priority: time %h cnt %0d full %b err %b run %b expected 0", o_time, o_lap_count, o_lap_full, o_preset_err, o_running); end
    exp_q.push_back(tm(0,0,0,1));
    i_run_stop = 1'b1; cyc(11);
    e = exp_q.pop_front();
    n_tests++; if (o_time !== e) begin n_fail++; $display("FAIL clear_idle_restart: got %h expected %h", o_time, e); end
    i_lap = 1'b1; cyc(); i_lap = 1'b0; cyc(3);
    #2 reset = 1'b1; #1;
    n_tests++; if ({o_time, o_lap_time, o_lap_count, o_lap_full, o_running, o_expired, o_rollover, o_preset_err} !== 56'd0) begin
      n_fail++; $display("FAIL async_reset: time %h cnt %0d run %b expected 0", o_time, o_lap_count, o_running); end
    i_run_stop = 1'b0;
    @(negedge clk); reset = 1'b0; cyc(2);
    n_tests++; if ({o_time, o_lap_time, o_lap_count, o_lap_full, o_running, o_expired, o_rollover, o_preset_err} !== 56'd0) begin
      n_fail++; $display("FAIL after_reset: time %h cnt %0d run %b expected 0", o_time, o_lap_count, o_running); end
  endtask

  initial begin
    reset = 1'b1; i_run_stop = 1'b0; i_clear = 1'b0; i_count_mode = 1'b0; i_lap = 1'b0;
    i_lap_rd_idx = 2'd0; i_preset_valid = 1'b0; i_preset_time = 24'd0;
    test_reset();
    test_run_pause();
    test_up_wrap();
    test_down_expiry();
    test_preset_guard();
    test_laps();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch_core.md
# lap_stopwatch_core

Parametrised stopwatch/timer core that generalises the fixed 100 Hz stopwatch datapath. It adds configurable clock and tick rates, a run-state machine, loadable countdown presets that stop and latch on expiry instead of wrapping, and a LAP_DEPTH-entry lap-capture buffer. It sits between the control unit (button/switch decode) and the display mux/fnd controller. Its packed time output uses the existing 24-bit layout: hour[23:19], min[18:13], sec[12:7], frac[6:0].

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, fractional-second resolution; frac counts 0..TICK_HZ-1; legal range 2..100
- HOUR_MAX, 24, hour modulus; legal range 2..32
- LAP_DEPTH, 4, lap buffer entries; legal range 1..16
- clk  in  1  system clock; one clock domain only
- reset  in  1  asynchronous, active-high reset
- i_run_stop  in  1  level; 1 = request run, 0 = request pause
- i_clear  in  1  one-cycle pulse; zeroes time, empties lap buffer, returns to IDLE
- i_count_mode  in  1  0 = count up, 1 = count down; sampled on every tick
- i_lap  in  1  one-cycle pulse; capture current o_time into the lap buffer
- i_lap_rd_idx  in  $clog2(LAP_DEPTH) (min 1)  lap read index; 0 = oldest entry
- i_preset_valid  in  1  one-cycle pulse; load i_preset_time
- i_preset_time  in  24  packed preset value
- o_time  out  24  current packed time, registered
- o_lap_time  out  24  lap_mem[i_lap_rd_idx], combinational; 0 if idx >= o_lap_count
- o_lap_count  out  $clog2(LAP_DEPTH+1)  number of valid laps
- o_lap_full  out  1  o_lap_count == LAP_DEPTH
- o_running  out  1  state == RUN
- o_expired  out  1  sticky; state == EXPIRED
- o_rollover  out  1  one-cycle pulse on up-count wrap 23:59:59:99 -> 0
- o_preset_err  out  1  one-cycle pulse when a preset is rejected

## Operation
- DIV = CLK_HZ/TICK_HZ (integer). The prescaler is $clog2(DIV) bits.
- The prescaler counts only in RUN. It holds its value in PAUSE, and is zeroed in IDLE, on clear, and on entering EXPIRED.
- A tick is the cycle in which prescaler == DIV-1.
- States and transitions:
  - IDLE: on i_run_stop=1 go to RUN.
  - RUN: on i_run_stop=0 go to PAUSE.
  - PAUSE: on i_run_stop=1 go to RUN.
  - EXPIRED: any state goes to IDLE on i_clear; EXPIRED is otherwise left only by a valid preset (to IDLE).
- Up count (tick, mode 0): frac increments; each field wraps at its modulus (TICK_HZ, 60, 60, HOUR_MAX) and carries into the next field in the same cycle. Full wrap to 0 asserts o_rollover.
- Down count (tick, mode 1): fields borrow symmetrically. A tick at time 0 does not wrap; time stays 0 and state goes to EXPIRED. Count and pause resume only after clear or preset.
- Preset: accepted only when not in RUN. It is rejected (o_preset_err, time unchanged) if frac >= TICK_HZ, sec >= 60, min >= 60, or hour >= HOUR_MAX, or if it arrives in RUN. An accepted preset in EXPIRED goes to IDLE.
- Lap: on i_lap in any state, the pre-update o_time of that cycle is written at index o_lap_count, and count increments. When full, the lap is dropped and the buffer is unchanged.
- Priority per cycle: reset > i_clear > i_preset_valid > tick/lap/state change. Lap and tick in the same cycle: lap stores the old value and time advances.

## Timing
- Reset values: o_time=0, all lap entries 0, o_lap_count=0, state IDLE, prescaler 0. All flags are 0.
- o_time changes on the edge ending the tick cycle. The first advance after IDLE->RUN comes DIV cycles after i_run_stop is seen high.
- The state register updates one edge after the input. o_running follows the state register.
- Clear and preset take effect on the next edge. o_time shows the new value one cycle after the pulse.
- o_lap_count and the buffer update on the edge after i_lap. o_lap_time is combinational from the registered memory.
- o_expired rises on the same edge that would have decremented below 0.
- o_rollover and o_preset_err are registered. Each is high exactly one cycle, the cycle after the causing event.
- Reset mid-count or mid-lap returns every register to its reset value immediately (asynchronous).

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Run/pause: run 250 cycles, then pause 100 cycles, then run 50 cycles. Required: frac=30, and the prescaler value is preserved across the pause.
- Up wrap: preset 23:59:59:99, then run 10 cycles. Required: o_time=0 and o_rollover high exactly 1 cycle.
- Down expiry: preset 00:00:01:00, mode 1, run. Required: 0 is reached after 100 ticks, o_expired=1 on the next tick, time stays 0, and run has no effect until a preset is accepted.
- Preset guard: preset sec=60 in IDLE, then a valid preset during RUN. Required: two o_preset_err pulses and o_time unchanged.
- Laps with LAP_DEPTH=4: six i_lap pulses while running, one of them on a tick cycle. Required: o_lap_count=4, o_lap_full=1, entries 0..3 hold the first four captured (pre-tick) values, and idx reads beyond the count return 0.
- Clear/reset priority: i_clear with i_preset_valid in the same cycle, then assert reset mid-RUN. Required: time=0, laps empty, IDLE; after reset all outputs are 0.
